// File: rtl/jtopll_wrseq_pkg.sv
// Shared types, state encoding and default OPLL timing for the jtopll_wrseq write sequencer.
package jtopll_wrseq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_A_STB  = 3'd1,
      ST_A_WAIT = 3'd2,
      ST_D_STB  = 3'd3,
      ST_D_WAIT = 3'd4
   } state_e;

   localparam int STB_LEN_DEF = 2;
   localparam int AWAIT_DEF   = 12;
   localparam int DWAIT_DEF   = 84;
   localparam int SHADOW_SIZE = 64;

   typedef struct packed {
      logic [7:0] rnum;
      logic [7:0] val;
   } wr_pair_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/jtopll_wrseq_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered occupancy; DEPTH must be a power of two.
module jtopll_wrseq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: storage has no reset; the pointers and level alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

endmodule

// File: rtl/jtopll_wrseq.sv
// OPLL CPU-port write sequencer: queues (reg, value) pairs and issues address/data strobes timed in cen ticks.
// Define JTOPLL_WRSEQ_CACHE_EN to add a 64-entry shadow that drops writes repeating the stored value.
module jtopll_wrseq
   import jtopll_wrseq_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int STB_LEN = STB_LEN_DEF,
   parameter int AWAIT   = AWAIT_DEF,
   parameter int DWAIT   = DWAIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_reg,
   input  logic [7:0]             in_val,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]             din,
   output logic                   addr,
   output logic                   cs_n,
   output logic                   wr_n
);

   localparam int               CNT_W      = $clog2(max3(STB_LEN, AWAIT, DWAIT) + 1);
   localparam logic [CNT_W-1:0] STB_LOAD   = CNT_W'(STB_LEN - 1);
   localparam logic [CNT_W-1:0] AWAIT_LOAD = CNT_W'(AWAIT - 1);
   localparam logic [CNT_W-1:0] DWAIT_LOAD = CNT_W'(DWAIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       din_q, din_d;
   logic [7:0]       val_q, val_d;
   logic             addr_q, addr_d;
   logic             stb_n_q, stb_n_d;
   logic             fifo_full, fifo_empty;
   logic             push, pop, take_head, skip;
   logic [15:0]      head_raw;
   wr_pair_t         head;

   assign push = in_valid && !fifo_full;

   jtopll_wrseq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data ({in_reg, in_val}),
      .pop     (pop),
      .rd_data (head_raw),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head = wr_pair_t'(head_raw);

`ifdef JTOPLL_WRSEQ_CACHE_EN
   logic [7:0] shadow_q [SHADOW_SIZE];
   logic [7:0] cur_reg_q, cur_reg_d;
   logic       shadow_we;

   assign skip      = (head.rnum < 8'h40) && (shadow_q[head.rnum[5:0]] == head.val);
   assign cur_reg_d = (take_head && !skip) ? head.rnum : cur_reg_q;
   // Shadow is updated on the tick that enters D_STB, i.e. when the data strobe is committed.
   assign shadow_we = cen && (state_q == ST_A_WAIT) && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SHADOW_SIZE; i++) shadow_q[i] <= '0;
         cur_reg_q <= '0;
      end else begin
         cur_reg_q <= cur_reg_d;
         if (shadow_we && (cur_reg_q < 8'h40)) shadow_q[cur_reg_q[5:0]] <= val_q;
      end
   end
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      din_d     = din_q;
      val_d     = val_q;
      addr_d    = addr_q;
      stb_n_d   = stb_n_q;
      take_head = 1'b0;
      if (cen) begin
         case (state_q)
            ST_IDLE: take_head = !fifo_empty;
            ST_A_STB: begin
               if (cnt_q == '0) begin
                  stb_n_d = 1'b1;
                  state_d = ST_A_WAIT;
                  cnt_d   = AWAIT_LOAD;
               end else cnt_d = cnt_q - 1'b1;
            end
            ST_A_WAIT: begin
               if (cnt_q == '0) begin
                  din_d   = val_q;
                  addr_d  = 1'b1;
                  stb_n_d = 1'b0;
                  state_d = ST_D_STB;
                  cnt_d   = STB_LOAD;
               end else cnt_d = cnt_q - 1'b1;
            end
            ST_D_STB: begin
               if (cnt_q == '0) begin
                  stb_n_d = 1'b1;
                  state_d = ST_D_WAIT;
                  cnt_d   = DWAIT_LOAD;
               end else cnt_d = cnt_q - 1'b1;
            end
            ST_D_WAIT: begin
               if (cnt_q == '0) begin
                  state_d   = ST_IDLE;
                  take_head = !fifo_empty;
               end else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
         // A popped pair that is not skipped starts its address strobe on this same tick.
         if (take_head && !skip) begin
            din_d   = head.rnum;
            val_d   = head.val;
            addr_d  = 1'b0;
            stb_n_d = 1'b0;
            state_d = ST_A_STB;
            cnt_d   = STB_LOAD;
         end
      end
   end

   assign pop = take_head;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         din_q   <= '0;
         val_q   <= '0;
         addr_q  <= 1'b0;
         stb_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         val_q   <= val_d;
         addr_q  <= addr_d;
         stb_n_q <= stb_n_d;
      end
   end

   assign in_ready = !fifo_full;
   assign busy     = !fifo_empty || (state_q != ST_IDLE);
   assign din      = din_q;
   assign addr     = addr_q;
   assign cs_n     = stb_n_q;
   assign wr_n     = stb_n_q;

endmodule

// File: tb/tb_jtopll_wrseq.sv
// Scoreboard bench for jtopll_wrseq: expected strobes queued at push, compared when cs_n falls.
module tb_jtopll_wrseq;

   localparam int DEPTH   = 4;
   localparam int STB_LEN = 2;
   localparam int AWAIT   = 12;
   localparam int DWAIT   = 84;
   localparam int PERIOD  = 2 * STB_LEN + AWAIT + DWAIT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cen = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_reg = '0;
   logic [7:0] in_val = '0;
   logic       in_ready, busy, addr, cs_n, wr_n;
   logic [7:0] din;
   logic [2:0] level;

   always #5 clk = ~clk;

   jtopll_wrseq #(
      .DEPTH   (DEPTH),
      .STB_LEN (STB_LEN),
      .AWAIT   (AWAIT),
      .DWAIT   (DWAIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_reg   (in_reg),
      .in_val   (in_val),
      .busy     (busy),
      .level    (level),
      .din      (din),
      .addr     (addr),
      .cs_n     (cs_n),
      .wr_n     (wr_n)
   );

   typedef struct {
      logic       a;
      logic [7:0] d;
   } stb_t;

   stb_t sb[$];
   int   addr_falls[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   cen_div = 1;
   bit   mon_en = 1'b0;
   int   strobes = 0;
   int   data_rise_cyc = 0;
   int   idle_cyc = 0;

`ifdef JTOPLL_WRSEQ_CACHE_EN
   logic [7:0] model_shadow [64];
   localparam int T5_STROBES = 8;
`else
   localparam int T5_STROBES = 10;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         if (cen_div == 0) begin
            cen = 1'b0;
            ph  = 0;
         end else begin
            cen = (ph == 0);
            ph  = (ph + 1 >= cen_div) ? 0 : ph + 1;
         end
      end
   end

   logic       prev_cs = 1'b1;
   logic [7:0] held_din = '0;
   logic       held_addr = 1'b0;
   bit         unstable = 1'b0;
   int         fall_cyc = 0;
   int         rise_cyc = 0;

   always @(negedge clk) begin
      stb_t e;
      if (!mon_en) prev_cs = 1'b1;
      else begin
         if (prev_cs && !cs_n) begin
            strobes++;
            check("wr_n_fall", wr_n, 0);
            if (sb.size() == 0) check("strobe_expected", cs_n, 1);
            else begin
               e = sb.pop_front();
               check("addr", addr, e.a);
               check("din", din, e.d);
            end
            if (addr) check("await_gap", cyc - rise_cyc, AWAIT * cen_div);
            else addr_falls.push_back(cyc);
            held_din  = din;
            held_addr = addr;
            unstable  = 1'b0;
            fall_cyc  = cyc;
         end else if (!prev_cs && cs_n) begin
            check("wr_n_rise", wr_n, 1);
            check("stb_len", cyc - fall_cyc, STB_LEN * cen_div);
            check("stable_in_stb", unstable, 0);
            rise_cyc = cyc;
            if (held_addr) data_rise_cyc = cyc;
         end else if (!cs_n && (din !== held_din || addr !== held_addr)) unstable = 1'b1;
         prev_cs = cs_n;
      end
   end

   task automatic clear_model();
      sb.delete();
`ifdef JTOPLL_WRSEQ_CACHE_EN
      for (int i = 0; i < 64; i++) model_shadow[i] = '0;
`endif
   endtask

   task automatic model_push(input logic [7:0] r, input logic [7:0] v);
      bit drop;
      drop = 1'b0;
`ifdef JTOPLL_WRSEQ_CACHE_EN
      if (r < 8'h40) begin
         if (model_shadow[r[5:0]] == v) drop = 1'b1;
         else model_shadow[r[5:0]] = v;
      end
`endif
      if (!drop) begin
         sb.push_back('{a: 1'b0, d: r});
         sb.push_back('{a: 1'b1, d: v});
      end
   endtask

   task automatic send(input logic [7:0] r, input logic [7:0] v);
      int   n;
      logic rdy;
      n = 0;
      in_valid = 1'b1;
      in_reg   = r;
      in_val   = v;
      forever begin
         rdy = in_ready;
         @(negedge clk);
         if (rdy) break;
         n++;
         if (n > 2000) begin
            check("send_timeout", rdy, 1);
            break;
         end
      end
      in_valid = 1'b0;
      model_push(r, v);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      idle_cyc = cyc;
      check("idle_timeout", busy, 0);
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic check_spacing(input int count, input int exp);
      check("addr_count", addr_falls.size(), count);
      for (int i = 1; i < addr_falls.size(); i++)
         check("addr_spacing", addr_falls[i] - addr_falls[i-1], exp);
      addr_falls.delete();
   endtask

   initial begin
      int n;
      int s0;
      clear_model();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      check("rst_din", din, 0);
      check("rst_addr", addr, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_wr_n", wr_n, 1);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);

      // single pair, cen every clk
      addr_falls.delete();
      send(8'h10, 8'hAB);
      wait_idle(1000);
      check("busy_tail", idle_cyc - data_rise_cyc, DWAIT);
      check_spacing(1, PERIOD);

      // fill FIFO with FSM frozen, then release and watch full-pop
      cen_div = 0;
      repeat (2) @(negedge clk);
      send(8'h01, 8'h11);
      send(8'h02, 8'h22);
      send(8'h03, 8'h33);
      send(8'h04, 8'h44);
      check("full_level", level, DEPTH);
      check("full_ready", in_ready, 0);
      in_valid = 1'b1;
      in_reg   = 8'h05;
      in_val   = 8'h55;
      repeat (3) @(negedge clk);
      check("held_ready", in_ready, 0);
      check("held_level", level, DEPTH);
      cen_div = 1;
      n = 0;
      while (level == 3'(DEPTH) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("pop_full_level", level, DEPTH - 1);
      check("pop_full_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      model_push(8'h05, 8'h55);
      check("refill_level", level, DEPTH);
      wait_idle(5000);
      check_spacing(5, PERIOD);

      // cen every 4th clk
      cen_div = 4;
      repeat (4) @(negedge clk);
      send(8'h21, 8'h5A);
      send(8'h22, 8'hA5);
      wait_idle(5000);
      check_spacing(2, PERIOD * 4);
      cen_div = 1;
      repeat (4) @(negedge clk);

      // reset during data strobe
      send(8'h30, 8'h5F);
      send(8'h31, 8'h22);
      n = 0;
      while (!(cs_n === 1'b0 && addr === 1'b1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t4_in_dstb", addr, 1);
      rst_n  = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      check("t4_cs_n", cs_n, 1);
      check("t4_wr_n", wr_n, 1);
      check("t4_level", level, 0);
      check("t4_busy", busy, 0);
      check("t4_din", din, 0);
      check("t4_addr", addr, 0);
      clear_model();
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      s0 = strobes;
      repeat (150) @(negedge clk);
      check("t4_no_strobe", strobes - s0, 0);
      addr_falls.delete();
      send(8'h20, 8'h11);
      wait_idle(1000);
      check_spacing(1, PERIOD);

      // repeated writes, with or without the shadow cache
      s0 = strobes;
      send(8'h30, 8'h5F);
      send(8'h30, 8'h5F);
      send(8'h30, 8'h60);
      send(8'h40, 8'h00);
      send(8'h40, 8'h00);
      wait_idle(5000);
      check("t5_strobes", strobes - s0, T5_STROBES);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
